// File: rtl/mem_wb_skid.sv
// MEM/WB stage register with valid/ready handshake on both sides and a 2-entry skid buffer.
// mem_ready is a flop; a saturating counter records back-pressured cycles.
module mem_wb_skid #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned IDX_W         = 5,
   parameter bit          ZERO_SUPPRESS = 1'b1,
   parameter int unsigned CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [IDX_W-1:0]  mem_rd_idx,
   input  logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [IDX_W-1:0]  wb_rd_idx,
   output logic              wb_rd_en,
   output logic [DATA_W-1:0] wb_rd_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_mem_ready;
   logic              r_h_valid;
   logic [IDX_W-1:0]  r_h_idx;
   logic              r_h_en;
   logic [DATA_W-1:0] r_h_data;
   logic              r_s_valid;
   logic [IDX_W-1:0]  r_s_idx;
   logic              r_s_en;
   logic [DATA_W-1:0] r_s_data;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_accept;
   logic w_pop;
   logic w_in_en;

   assign w_accept = mem_valid & r_mem_ready;
   assign w_pop    = r_h_valid & wb_ready;
   // Writes to x0 are neutralised at capture so the head never presents them as enabled.
   assign w_in_en  = mem_rd_en & ~(ZERO_SUPPRESS && (mem_rd_idx == '0));

   // Occupancy FSM with head/skid storage; mem_ready tracks next occupancy != FULL.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= EMPTY;
         r_mem_ready <= 1'b1;
         r_h_valid   <= 1'b0;
         r_h_idx     <= '0;
         r_h_en      <= 1'b0;
         r_h_data    <= '0;
         r_s_valid   <= 1'b0;
         r_s_idx     <= '0;
         r_s_en      <= 1'b0;
         r_s_data    <= '0;
      end else if (flush) begin
         r_state     <= EMPTY;
         r_mem_ready <= 1'b1;
         r_h_valid   <= 1'b0;
         r_s_valid   <= 1'b0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_state   <= ONE;
                  r_h_valid <= 1'b1;
                  r_h_idx   <= mem_rd_idx;
                  r_h_en    <= w_in_en;
                  r_h_data  <= mem_rd_data;
               end
            end
            ONE: begin
               if (w_accept && w_pop) begin
                  r_h_idx  <= mem_rd_idx;
                  r_h_en   <= w_in_en;
                  r_h_data <= mem_rd_data;
               end else if (w_accept) begin
                  r_state     <= FULL;
                  r_mem_ready <= 1'b0;
                  r_s_valid   <= 1'b1;
                  r_s_idx     <= mem_rd_idx;
                  r_s_en      <= w_in_en;
                  r_s_data    <= mem_rd_data;
               end else if (w_pop) begin
                  r_state   <= EMPTY;
                  r_h_valid <= 1'b0;
               end
            end
            FULL: begin
               if (w_pop) begin
                  r_state     <= ONE;
                  r_mem_ready <= 1'b1;
                  r_s_valid   <= 1'b0;
                  r_h_idx     <= r_s_idx;
                  r_h_en      <= r_s_en;
                  r_h_data    <= r_s_data;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_mem_ready <= 1'b1;
               r_h_valid   <= 1'b0;
               r_s_valid   <= 1'b0;
            end
         endcase
      end
   end

   // Saturating stall counter; flush leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (r_h_valid && !wb_ready && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign mem_ready  = r_mem_ready;
   assign wb_valid   = r_h_valid;
   assign wb_rd_idx  = r_h_idx;
   assign wb_rd_en   = r_h_en & r_h_valid;
   assign wb_rd_data = r_h_data;
   assign occupancy  = 2'(r_state);
   assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid: default build plus a ZERO_SUPPRESS=0, CNT_W=4 build on shared stimulus.
module tb_mem_wb_skid;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        mem_valid;
   logic [4:0]  mem_rd_idx;
   logic        mem_rd_en;
   logic [31:0] mem_rd_data;
   logic        wb_ready;

   logic        a_mem_ready, a_wb_valid, a_wb_rd_en;
   logic [4:0]  a_wb_rd_idx;
   logic [31:0] a_wb_rd_data;
   logic [1:0]  a_occ;
   logic [15:0] a_stall;

   logic        b_mem_ready, b_wb_valid, b_wb_rd_en;
   logic [4:0]  b_wb_rd_idx;
   logic [31:0] b_wb_rd_data;
   logic [1:0]  b_occ;
   logic [3:0]  b_stall;

   int n_total;
   int n_bad;

   mem_wb_skid u_dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(a_mem_ready),
      .mem_rd_idx(mem_rd_idx), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
      .wb_valid(a_wb_valid), .wb_ready(wb_ready),
      .wb_rd_idx(a_wb_rd_idx), .wb_rd_en(a_wb_rd_en), .wb_rd_data(a_wb_rd_data),
      .occupancy(a_occ), .stall_cnt(a_stall)
   );

   mem_wb_skid #(.ZERO_SUPPRESS(1'b0), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(b_mem_ready),
      .mem_rd_idx(mem_rd_idx), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
      .wb_valid(b_wb_valid), .wb_ready(wb_ready),
      .wb_rd_idx(b_wb_rd_idx), .wb_rd_en(b_wb_rd_en), .wb_rd_data(b_wb_rd_data),
      .occupancy(b_occ), .stall_cnt(b_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [4:0] idx, input logic en, input logic [31:0] data);
      mem_valid   = 1'b1;
      mem_rd_idx  = idx;
      mem_rd_en   = en;
      mem_rd_data = data;
   endtask

   initial begin
      n_total     = 0;
      n_bad       = 0;
      rst         = 1'b1;
      flush       = 1'b0;
      mem_valid   = 1'b0;
      mem_rd_idx  = '0;
      mem_rd_en   = 1'b0;
      mem_rd_data = '0;
      wb_ready    = 1'b0;

      // Reset
      tick();
      tick();
      check("rst_wb_valid", 64'(a_wb_valid), 64'd0);
      check("rst_wb_rd_en", 64'(a_wb_rd_en), 64'd0);
      check("rst_wb_rd_idx", 64'(a_wb_rd_idx), 64'd0);
      check("rst_wb_rd_data", 64'(a_wb_rd_data), 64'd0);
      check("rst_occ", 64'(a_occ), 64'd0);
      check("rst_stall", 64'(a_stall), 64'd0);
      check("rst_mem_ready", 64'(a_mem_ready), 64'd1);
      rst = 1'b0;

      // Basic flow
      wb_ready = 1'b1;
      offer(5'd3, 1'b1, 32'hDEADBEEF);
      tick();
      mem_valid = 1'b0;
      check("basic_valid", 64'(a_wb_valid), 64'd1);
      check("basic_idx", 64'(a_wb_rd_idx), 64'd3);
      check("basic_en", 64'(a_wb_rd_en), 64'd1);
      check("basic_data", 64'(a_wb_rd_data), 64'hDEADBEEF);
      check("basic_occ", 64'(a_occ), 64'd1);
      tick();
      check("basic_empty", 64'(a_wb_valid), 64'd0);
      check("basic_hold_data", 64'(a_wb_rd_data), 64'hDEADBEEF);
      check("basic_en_off", 64'(a_wb_rd_en), 64'd0);

      // Back-pressure and skid
      wb_ready = 1'b0;
      offer(5'd1, 1'b1, 32'h11);
      tick();
      check("bp_occ1", 64'(a_occ), 64'd1);
      check("bp_ready1", 64'(a_mem_ready), 64'd1);
      check("bp_stall0", 64'(a_stall), 64'd0);
      offer(5'd2, 1'b1, 32'h22);
      tick();
      mem_valid = 1'b0;
      check("bp_occ2", 64'(a_occ), 64'd2);
      check("bp_ready_full", 64'(a_mem_ready), 64'd0);
      check("bp_stall1", 64'(a_stall), 64'd1);
      check("bp_head_a", 64'(a_wb_rd_data), 64'h11);
      tick();
      check("bp_stall2", 64'(a_stall), 64'd2);
      check("bp_hold_full", 64'(a_occ), 64'd2);
      wb_ready = 1'b1;
      tick();
      check("bp_head_b", 64'(a_wb_rd_data), 64'h22);
      check("bp_idx_b", 64'(a_wb_rd_idx), 64'd2);
      check("bp_occ_after", 64'(a_occ), 64'd1);
      check("bp_ready_back", 64'(a_mem_ready), 64'd1);
      check("bp_stall_frozen", 64'(a_stall), 64'd2);
      check("bp_stall_b", 64'(b_stall), 64'd2);
      tick();
      check("bp_drained", 64'(a_wb_valid), 64'd0);

      // Streaming, one beat per cycle
      for (int i = 0; i < 100; i++) begin
         offer(5'd7, 1'b1, 32'(i));
         tick();
         check("stream_valid", 64'(a_wb_valid), 64'd1);
         check("stream_data", 64'(a_wb_rd_data), 64'(i));
         check("stream_occ", 64'(a_occ), 64'd1);
      end
      mem_valid = 1'b0;
      tick();
      check("stream_end", 64'(a_occ), 64'd0);

      // x0 suppression
      offer(5'd0, 1'b1, 32'h55);
      tick();
      mem_valid = 1'b0;
      check("x0_valid", 64'(a_wb_valid), 64'd1);
      check("x0_en_sup", 64'(a_wb_rd_en), 64'd0);
      check("x0_data", 64'(a_wb_rd_data), 64'h55);
      check("x0_en_nosup", 64'(b_wb_rd_en), 64'd1);
      tick();

      // Flush in FULL with a beat offered
      wb_ready = 1'b0;
      offer(5'd4, 1'b1, 32'hA1);
      tick();
      offer(5'd5, 1'b1, 32'hA2);
      tick();
      check("fl_full", 64'(a_occ), 64'd2);
      flush = 1'b1;
      offer(5'd6, 1'b1, 32'hBB);
      tick();
      flush     = 1'b0;
      mem_valid = 1'b0;
      check("fl_occ", 64'(a_occ), 64'd0);
      check("fl_valid", 64'(a_wb_valid), 64'd0);
      check("fl_ready", 64'(a_mem_ready), 64'd1);
      check("fl_stall", 64'(a_stall), 64'd4);
      wb_ready = 1'b1;
      tick();
      check("fl_nothing", 64'(a_wb_valid), 64'd0);
      tick();
      check("fl_nothing2", 64'(a_wb_valid), 64'd0);

      // Flush in ONE while mem_ready=1: offered beat dropped
      wb_ready = 1'b0;
      offer(5'd8, 1'b1, 32'hC1);
      tick();
      check("fl1_occ1", 64'(a_occ), 64'd1);
      flush = 1'b1;
      offer(5'd9, 1'b1, 32'hC2);
      tick();
      flush     = 1'b0;
      mem_valid = 1'b0;
      check("fl1_occ", 64'(a_occ), 64'd0);
      check("fl1_valid", 64'(a_wb_valid), 64'd0);
      tick();
      check("fl1_nothing", 64'(a_wb_valid), 64'd0);
      check("fl1_stall", 64'(a_stall), 64'd5);

      // Counter saturation on the 4-bit build
      offer(5'd10, 1'b1, 32'hD1);
      tick();
      mem_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("sat_b", 64'(b_stall), 64'd15);
      check("sat_a", 64'(a_stall), 64'd25);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("sat_rst_b", 64'(b_stall), 64'd0);
      check("sat_rst_a", 64'(a_stall), 64'd0);
      check("rst2_occ", 64'(a_occ), 64'd0);
      check("rst2_data", 64'(a_wb_rd_data), 64'd0);
      check("rst2_idx", 64'(a_wb_rd_idx), 64'd0);
      check("rst2_ready", 64'(a_mem_ready), 64'd1);
      wb_ready = 1'b1;
      tick();
      check("rst2_discard", 64'(a_wb_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
- Parametrised successor of the MEM/WB stage register.
- Adds a valid/ready handshake on both sides, a 2-entry skid buffer so that upstream ready is a pure register output, synchronous flush, optional x0-write suppression and a saturating stall counter.
- Sits between the memory stage and the register-file write port; the writeback side may back-pressure it, for example on a register-file port conflict.

Parameters:
- DATA_W, 32, width of the writeback data.
- IDX_W, 5, width of the destination register index.
- ZERO_SUPPRESS, 1, when 1, a beat with rd_idx==0 is stored with rd_en forced to 0.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- mem_valid  in  1  upstream beat valid.
- mem_ready  out  1  upstream may transfer; driven directly from a register.
- mem_rd_idx  in  IDX_W  destination index.
- mem_rd_en  in  1  write enable.
- mem_rd_data  in  DATA_W  write data.
- wb_valid  out  1  downstream beat valid.
- wb_ready  in  1  downstream accepts.
- wb_rd_idx  out  IDX_W  destination index of the head beat.
- wb_rd_en  out  1  head rd_en AND wb_valid.
- wb_rd_data  out  DATA_W  head write data.
- occupancy  out  2  number of beats held (0..2).
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- Storage: head register H (drives the wb_* outputs) and skid register S, each holding {valid, idx, en, data}.
- State is given by occupancy:
  - EMPTY = 0: neither valid.
  - ONE = 1: H valid only.
  - FULL = 2: H and S valid.
  - S is never valid while H is invalid.
- Transfers:
  - accept = mem_valid & mem_ready.
  - pop = wb_valid & wb_ready.
- mem_ready is registered and equals (next occupancy != FULL). It is 1 after reset and 0 exactly while in FULL.
- Transitions (flush=0):
  - EMPTY: accept -> ONE, beat into H.
  - ONE, accept & pop -> ONE, new beat into H.
  - ONE, accept & !pop -> FULL, new beat into S.
  - ONE, pop & !accept -> EMPTY.
  - ONE, neither -> ONE, H held.
  - FULL, pop -> ONE, S moves into H. No accept is possible because mem_ready=0.
  - FULL, !pop -> FULL, all held.
- Latency:
  - A beat accepted in cycle N into an EMPTY or popping-ONE block appears on wb_* in cycle N+1.
  - A beat parked in S appears in the cycle after H pops.
  - Beats leave in strict acceptance order; none is lost or duplicated.
- ZERO_SUPPRESS=1: a beat with mem_rd_idx==0 is stored with en=0. idx and data are stored unchanged and the beat still flows as valid.
- wb_rd_en = H.en & H.valid.
  - wb_rd_idx and wb_rd_data hold their last value when wb_valid=0.
- flush=1:
  - Next cycle occupancy=0, wb_valid=0 and mem_ready=1.
  - Any beat offered in the flush cycle is dropped, even if mem_ready=1.
  - A pop in the flush cycle completes downstream; the block only clears its state.
  - idx and data registers are not cleared.
- stall_cnt:
  - Increments by 1 in each cycle where wb_valid & !wb_ready.
  - Saturates at 2^CNT_W-1.
  - Unaffected by flush; cleared only by rst.
- rst=1, which takes priority over flush:
  - Next cycle all valid=0, occupancy=0, mem_ready=1, wb_valid=0 and wb_rd_en=0.
  - wb_rd_idx=0, wb_rd_data=0 and stall_cnt=0.
  - A reset mid-transfer discards all held beats.
- Width rules: no arithmetic on the data path. stall_cnt is an unsigned CNT_W-bit counter that does not wrap.

Test Plan:
- Reset and basic flow: assert rst for 2 cycles, then push idx=3, en=1, data=0xDEADBEEF with wb_ready=1.
  - Required: all outputs are 0 and mem_ready=1 during reset.
  - Required: the beat appears on wb_* exactly 1 cycle after acceptance, with occupancy=1.
- Back-pressure and skid: hold wb_ready=0 and push beats A (data 0x11) and B (data 0x22) on consecutive cycles.
  - Required: occupancy goes 1 then 2, mem_ready=0 in FULL, and stall_cnt increments every stalled cycle.
  - Then release wb_ready: A then B are output on consecutive cycles, and mem_ready returns to 1 one cycle after A pops.
- Streaming: with wb_ready=1, push 100 back-to-back beats with data=i.
  - Required: 100 pops in order with data 0..99, no bubbles after the first, and occupancy stays at 1.
- x0 suppression: push idx=0, en=1, data=0x55.
  - Required: wb_valid=1, wb_rd_en=0 and wb_rd_data=0x55.
  - With ZERO_SUPPRESS=0 the same beat gives wb_rd_en=1.
- Flush in FULL: fill to FULL, then assert flush together with mem_valid=1.
  - Required: the next cycle has occupancy=0, wb_valid=0 and mem_ready=1; no flushed or offered beat ever appears; stall_cnt retains its value.
- Counter saturation: with CNT_W=4, stall for 20 cycles.
  - Required: stall_cnt stops at 15.
  - Then assert rst: stall_cnt=0 the next cycle.
